// File: rtl/control_sequencer_if.sv
// Control bus between the hardwired control sequencer and the datapath.
// The sequencer side (master) receives IR and Mem_ready and drives every
// control strobe. The datapath side (slave) sees the same signals in the
// opposite direction.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        Mem_ready;
  logic        PCout, MDRout, Zhighout, Zlowout;
  logic        PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin;
  logic        IncPC, Read;
  logic [15:0] Rout;
  logic [15:0] Rin;
  logic [7:0]  ALU_sel;
  logic        Run;
  logic [3:0]  T_state;

  modport master (
    input  IR, Mem_ready,
    output PCout, MDRout, Zhighout, Zlowout,
    output PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
    output IncPC, Read, Rout, Rin, ALU_sel, Run, T_state
  );

  modport slave (
    output IR, Mem_ready,
    input  PCout, MDRout, Zhighout, Zlowout,
    input  PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
    input  IncPC, Read, Rout, Rin, ALU_sel, Run, T_state
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired T-state control sequencer: fetch (T0..T2) followed by
// opcode-dependent execute steps (T3..T6). The outputs are Moore-decoded from
// the state and IR. The only exception is the PC writeback in T1, which waits
// for Mem_ready. Clear is synchronous. While it is high it also forces every
// output low, so an aborted instruction cannot emit a write strobe.
module control_sequencer (
  input logic                  Clock,
  input logic                  Clear,
  control_sequencer_if.master  bus
);

  typedef enum logic [3:0] {
    T0   = 4'd0,
    T1   = 4'd1,
    T2   = 4'd2,
    T3   = 4'd3,
    T4   = 4'd4,
    T5   = 4'd5,
    T6   = 4'd6,
    HALT = 4'd15
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t r_state;
  state_t w_next;

  // IR fields. They are only consulted in T3..T6, so IR may change freely
  // while the fetch is in progress.
  logic [4:0]  w_op;
  logic [3:0]  w_ra, w_rb, w_rc;
  logic        w_alu3, w_muldiv, w_unary, w_halt;
  logic [7:0]  w_alu_bit;

  assign w_op = bus.IR[31:27];
  assign w_ra = bus.IR[26:23];
  assign w_rb = bus.IR[22:19];
  assign w_rc = bus.IR[18:15];

  // Opcode class and the one-hot ALU select. Bit order is
  // {DIV,MUL,NOT,NEG,OR,AND,SUB,ADD}.
  always_comb begin
    w_alu3    = 1'b0;
    w_muldiv  = 1'b0;
    w_unary   = 1'b0;
    w_halt    = 1'b0;
    w_alu_bit = 8'h00;
    case (w_op)
      OP_ADD:  begin w_alu3   = 1'b1; w_alu_bit = 8'h01; end
      OP_SUB:  begin w_alu3   = 1'b1; w_alu_bit = 8'h02; end
      OP_AND:  begin w_alu3   = 1'b1; w_alu_bit = 8'h04; end
      OP_OR:   begin w_alu3   = 1'b1; w_alu_bit = 8'h08; end
      OP_NEG:  begin w_unary  = 1'b1; w_alu_bit = 8'h10; end
      OP_NOT:  begin w_unary  = 1'b1; w_alu_bit = 8'h20; end
      OP_MUL:  begin w_muldiv = 1'b1; w_alu_bit = 8'h40; end
      OP_DIV:  begin w_muldiv = 1'b1; w_alu_bit = 8'h80; end
      OP_HALT: w_halt = 1'b1;
      default: ;
    endcase
  end

  // State register: Clear returns to T0 on the edge.
  always_ff @(posedge Clock) begin
    if (Clear) r_state <= T0;
    else       r_state <= w_next;
  end

  // Next-state sequencing. NOP and undefined opcodes end at T3.
  always_comb begin
    w_next = r_state;
    case (r_state)
      T0:      w_next = T1;
      T1:      w_next = bus.Mem_ready ? T2 : T1;
      T2:      w_next = T3;
      T3: begin
        if (w_halt)                           w_next = HALT;
        else if (w_alu3 || w_muldiv || w_unary) w_next = T4;
        else                                  w_next = T0;
      end
      T4:      w_next = w_unary ? T0 : T5;
      T5:      w_next = w_muldiv ? T6 : T0;
      T6:      w_next = T0;
      HALT:    w_next = HALT;
      default: w_next = T0;
    endcase
  end

  logic        w_pcout, w_mdrout, w_zhighout, w_zlowout;
  logic        w_pcin, w_marin, w_mdrin, w_irin, w_yin, w_zin, w_hiin, w_loin;
  logic        w_incpc, w_read, w_run;
  logic [15:0] w_rout, w_rin;
  logic [7:0]  w_alu;
  logic [3:0]  w_tstate;

  // Control strobes for the current step. The Clear override comes last, so
  // nothing is asserted in a reset cycle.
  always_comb begin
    w_pcout    = 1'b0;
    w_mdrout   = 1'b0;
    w_zhighout = 1'b0;
    w_zlowout  = 1'b0;
    w_pcin     = 1'b0;
    w_marin    = 1'b0;
    w_mdrin    = 1'b0;
    w_irin     = 1'b0;
    w_yin      = 1'b0;
    w_zin      = 1'b0;
    w_hiin     = 1'b0;
    w_loin     = 1'b0;
    w_incpc    = 1'b0;
    w_read     = 1'b0;
    w_rout     = 16'h0000;
    w_rin      = 16'h0000;
    w_alu      = 8'h00;
    w_run      = (r_state != HALT);
    w_tstate   = r_state;
    case (r_state)
      T0: begin
        w_pcout = 1'b1;
        w_marin = 1'b1;
        w_incpc = 1'b1;
        w_zin   = 1'b1;
      end
      T1: begin
        w_read    = 1'b1;
        w_mdrin   = 1'b1;
        // The incremented PC is written back only once the read completes.
        w_zlowout = bus.Mem_ready;
        w_pcin    = bus.Mem_ready;
      end
      T2: begin
        w_mdrout = 1'b1;
        w_irin   = 1'b1;
      end
      T3: begin
        if (w_alu3) begin
          w_rout = 16'h0001 << w_rb;
          w_yin  = 1'b1;
        end else if (w_muldiv) begin
          w_rout = 16'h0001 << w_ra;
          w_yin  = 1'b1;
        end else if (w_unary) begin
          w_rout = 16'h0001 << w_rb;
          w_alu  = w_alu_bit;
          w_zin  = 1'b1;
        end
      end
      T4: begin
        if (w_alu3) begin
          w_rout = 16'h0001 << w_rc;
          w_alu  = w_alu_bit;
          w_zin  = 1'b1;
        end else if (w_muldiv) begin
          w_rout = 16'h0001 << w_rb;
          w_alu  = w_alu_bit;
          w_zin  = 1'b1;
        end else if (w_unary) begin
          w_zlowout = 1'b1;
          w_rin     = 16'h0001 << w_ra;
        end
      end
      T5: begin
        if (w_alu3) begin
          w_zlowout = 1'b1;
          w_rin     = 16'h0001 << w_ra;
        end else if (w_muldiv) begin
          w_zlowout = 1'b1;
          w_loin    = 1'b1;
        end
      end
      T6: begin
        if (w_muldiv) begin
          w_zhighout = 1'b1;
          w_hiin     = 1'b1;
        end
      end
      default: ;
    endcase
    if (Clear) begin
      w_pcout    = 1'b0;
      w_mdrout   = 1'b0;
      w_zhighout = 1'b0;
      w_zlowout  = 1'b0;
      w_pcin     = 1'b0;
      w_marin    = 1'b0;
      w_mdrin    = 1'b0;
      w_irin     = 1'b0;
      w_yin      = 1'b0;
      w_zin      = 1'b0;
      w_hiin     = 1'b0;
      w_loin     = 1'b0;
      w_incpc    = 1'b0;
      w_read     = 1'b0;
      w_rout     = 16'h0000;
      w_rin      = 16'h0000;
      w_alu      = 8'h00;
      w_run      = 1'b0;
      w_tstate   = 4'd0;
    end
  end

  assign bus.PCout    = w_pcout;
  assign bus.MDRout   = w_mdrout;
  assign bus.Zhighout = w_zhighout;
  assign bus.Zlowout  = w_zlowout;
  assign bus.PCin     = w_pcin;
  assign bus.MARin    = w_marin;
  assign bus.MDRin    = w_mdrin;
  assign bus.IRin     = w_irin;
  assign bus.Yin      = w_yin;
  assign bus.Zin      = w_zin;
  assign bus.HIin     = w_hiin;
  assign bus.LOin     = w_loin;
  assign bus.IncPC    = w_incpc;
  assign bus.Read     = w_read;
  assign bus.Rout     = w_rout;
  assign bus.Rin      = w_rin;
  assign bus.ALU_sel  = w_alu;
  assign bus.Run      = w_run;
  assign bus.T_state  = w_tstate;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboarded bench for control_sequencer. Each instruction expands into a
// list of per-cycle steps built from the micro-step table of its opcode. The
// driver applies the steps and queues the expected output word. A separate
// monitor pops the queue on every falling edge and compares.
module tb_control_sequencer;

  logic Clock = 1'b0;
  logic Clear;
  control_sequencer_if bus();

  control_sequencer dut (.Clock(Clock), .Clear(Clear), .bus(bus));

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic        run;
    logic [3:0]  t;
    logic        pcout, mdrout, zhighout, zlowout;
    logic        pcin, marin, mdrin, irin, yin, zin, hiin, loin;
    logic        incpc, read;
    logic [15:0] rout, rin;
    logic [7:0]  alu;
  } exp_t;

  typedef struct {
    exp_t        e;
    logic        mr;
    logic        clr;
    logic        real_ir;
    logic [31:0] ir;
  } step_t;

  step_t prog[$];
  exp_t  sb[$];
  int    errors = 0;
  int    checks = 0;

  function automatic exp_t base(input int t);
    exp_t e;
    e     = '0;
    e.run = (t != 15);
    e.t   = 4'(t);
    return e;
  endfunction

  task automatic add(input exp_t e, input logic mr, input logic clr,
                     input logic real_ir, input logic [31:0] ir);
    step_t s;
    s.e = e; s.mr = mr; s.clr = clr; s.real_ir = real_ir; s.ir = ir;
    prog.push_back(s);
  endtask

  task automatic add_clear();
    add('0, 1'($urandom), 1'b1, 1'b0, 32'h0);
  endtask

  // Reference expansion of one instruction into its expected cycles.
  task automatic gen_instr(input logic [31:0] ir, input int waits);
    exp_t e;
    int op, ra, rb, rc, abit;
    op = int'(ir[31:27]); ra = int'(ir[26:23]);
    rb = int'(ir[22:19]); rc = int'(ir[18:15]);
    e = base(0); e.pcout = 1; e.marin = 1; e.incpc = 1; e.zin = 1;
    add(e, 1'($urandom), 0, 0, ir);
    for (int w = 0; w < waits; w++) begin
      e = base(1); e.read = 1; e.mdrin = 1;
      add(e, 0, 0, 0, ir);
    end
    e = base(1); e.read = 1; e.mdrin = 1; e.zlowout = 1; e.pcin = 1;
    add(e, 1, 0, 0, ir);
    e = base(2); e.mdrout = 1; e.irin = 1;
    add(e, 1'($urandom), 0, 0, ir);
    case (op)
      3, 4, 5, 6: begin
        abit = op - 3;
        e = base(3); e.rout[rb] = 1; e.yin = 1; add(e, 1'($urandom), 0, 1, ir);
        e = base(4); e.rout[rc] = 1; e.alu[abit] = 1; e.zin = 1;
        add(e, 1'($urandom), 0, 1, ir);
        e = base(5); e.zlowout = 1; e.rin[ra] = 1; add(e, 1'($urandom), 0, 1, ir);
      end
      15, 16: begin
        abit = (op == 15) ? 6 : 7;
        e = base(3); e.rout[ra] = 1; e.yin = 1; add(e, 1'($urandom), 0, 1, ir);
        e = base(4); e.rout[rb] = 1; e.alu[abit] = 1; e.zin = 1;
        add(e, 1'($urandom), 0, 1, ir);
        e = base(5); e.zlowout = 1; e.loin = 1; add(e, 1'($urandom), 0, 1, ir);
        e = base(6); e.zhighout = 1; e.hiin = 1; add(e, 1'($urandom), 0, 1, ir);
      end
      17, 18: begin
        abit = (op == 17) ? 4 : 5;
        e = base(3); e.rout[rb] = 1; e.alu[abit] = 1; e.zin = 1;
        add(e, 1'($urandom), 0, 1, ir);
        e = base(4); e.zlowout = 1; e.rin[ra] = 1; add(e, 1'($urandom), 0, 1, ir);
      end
      default: add(base(3), 1'($urandom), 0, 1, ir);
    endcase
  endtask

  // HALT: parks with everything low until a Clear pulse.
  task automatic gen_halt(input int n);
    gen_instr(32'hD800_0000, 0);
    for (int i = 0; i < n; i++) add(base(15), 1'($urandom), 0, 0, 32'h0);
    add_clear();
  endtask

  // Instruction cut short by Clear at step k of its expansion.
  task automatic gen_abort(input logic [31:0] ir, input int waits, input int k);
    int start;
    start = prog.size();
    gen_instr(ir, waits);
    while (prog.size() > start + k) void'(prog.pop_back());
    add_clear();
  endtask

  function automatic logic [31:0] rand_ir();
    logic [4:0] ops [10];
    logic [31:0] r;
    ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd15, 5'd16, 5'd17, 5'd18, 5'd26, 5'd31};
    r = $urandom;
    r[31:27] = ops[$urandom_range(0, 9)];
    if ($urandom_range(0, 9) == 0) r[31:27] = 5'($urandom_range(0, 31));
    if (r[31:27] == 5'd27) r[31:27] = 5'd26;
    return r;
  endfunction

  // Monitor: compares every presented cycle against the queued expectation.
  always @(negedge Clock) begin
    exp_t got, want;
    if (sb.size() > 0) begin
      want = sb.pop_front();
      got = '{run: bus.Run, t: bus.T_state, pcout: bus.PCout,
              mdrout: bus.MDRout, zhighout: bus.Zhighout, zlowout: bus.Zlowout,
              pcin: bus.PCin, marin: bus.MARin, mdrin: bus.MDRin,
              irin: bus.IRin, yin: bus.Yin, zin: bus.Zin, hiin: bus.HIin,
              loin: bus.LOin, incpc: bus.IncPC, read: bus.Read,
              rout: bus.Rout, rin: bus.Rin, alu: bus.ALU_sel};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got=%h want=%h (T got %0d want %0d)",
                 $time, got, want, got.t, want.t);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired with %0d steps left", prog.size());
    $fatal(1, "timeout");
  end

  initial begin
    step_t s;
    Clear = 1'b1;
    bus.IR = 32'h0;
    bus.Mem_ready = 1'b0;

    add_clear(); add_clear();
    gen_instr(32'h2292_0000, 0);            // SUB R5,R2,R4
    gen_instr(32'h2292_0000, 3);            // same with three T1 waits
    gen_instr(32'h7918_0000, 0);            // MUL R2,R3
    gen_instr(32'hF800_0000, 0);            // undefined opcode
    gen_instr(32'h8A00_0000, 1);            // NEG
    gen_abort(32'h2292_0000, 0, 4);         // Clear during T4 of SUB
    gen_instr(32'h1A00_0000, 0);            // ADD
    gen_halt(11);
    gen_instr(32'h2292_0000, 0);
    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = $urandom_range(0, 19);
      if (sel == 0)      gen_halt($urandom_range(1, 12));
      else if (sel < 4)  gen_abort(rand_ir(), $urandom_range(0, 3), $urandom_range(0, 6));
      else               gen_instr(rand_ir(), $urandom_range(0, 3));
    end

    while (prog.size() > 0) begin
      s = prog.pop_front();
      @(posedge Clock); #1;
      Clear         = s.clr;
      bus.Mem_ready = s.mr;
      bus.IR        = s.real_ir ? s.ir : $urandom;
      sb.push_back(s.e);
    end
    @(posedge Clock); #1;
    Clear = 1'b1;
    @(negedge Clock); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high; the clock port is named Clock and the reset port is named Clear.
REQ-002 Clock  input  1  system clock; all state changes occur on its rising edge.
REQ-003 Clear  input  1  synchronous active-high reset.
REQ-004 IR  input  32  instruction register contents from the datapath.
REQ-005 Mem_ready  input  1  memory read data valid on Mdatain this cycle.
REQ-006 PCout, MDRout, Zhighout, Zlowout  output  1 each  bus drive enables.
REQ-007 PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin  output  1 each  register load enables.
REQ-008 IncPC, Read  output  1 each  ALU PC-increment select; memory read / MDR source select.
REQ-009 Rout  output  16  one-hot general-register bus drive, bit n = Rn.
REQ-010 Rin  output  16  one-hot general-register load, bit n = Rn.
REQ-011 ALU_sel  output  8  one-hot ALU op {DIV,MUL,NOT,NEG,OR,AND,SUB,ADD}, bit0 = ADD.
REQ-012 Run  output  1  high while the sequencer executes; low in HALT and during Clear.
REQ-013 T_state  output  4  current state code: T0..T6 = 0..6, HALT = 15.

Function
REQ-014 Outputs SHALL be a combinational function of state and IR (Moore), except the T1 gating in REQ-017.
REQ-015 At most one bit of Rout, Rin and ALU_sel SHALL be high in any cycle.
REQ-016 T0: PCout, MARin, IncPC and Zin are high; next state T1.
REQ-017 T1: Read and MDRin are high; Zlowout and PCin are high only when Mem_ready=1; the sequencer holds in T1 while Mem_ready=0 and goes to T2 when Mem_ready=1.
REQ-018 T2: MDRout and IRin are high; next state T3.
REQ-019 Decode from T3 onward uses op=IR[31:27], ra=IR[26:23], rb=IR[22:19], rc=IR[18:15].
REQ-020 ADD 00011, SUB 00100, AND 00101, OR 00110:
  - T3: Rout[rb], Yin.
  - T4: Rout[rc], ALU_sel op bit, Zin.
  - T5: Zlowout, Rin[ra].
  - Next state T0.
REQ-021 MUL 01111, DIV 10000:
  - T3: Rout[ra], Yin.
  - T4: Rout[rb], ALU_sel op bit, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
  - Next state T0.
REQ-022 NEG 10001, NOT 10010:
  - T3: Rout[rb], ALU_sel op bit, Zin.
  - T4: Zlowout, Rin[ra].
  - Next state T0.
REQ-023 HALT 11011: T3 asserts no outputs; next state HALT; HALT asserts no outputs, Run=0, and is left only by Clear.
REQ-024 NOP 11010 and every undefined opcode: T3 asserts no outputs; next state T0.
REQ-025 Latency with Mem_ready=1 throughout: 3-register ALU op = 6 cycles T0..T5; MUL/DIV = 7 cycles; NEG/NOT = 5 cycles; each wait cycle in T1 adds 1.
REQ-026 IR SHALL be sampled only in T3..T6; IR changes in T0..T2 have no effect on outputs.

Reset
REQ-027 In any cycle with Clear=1, every output SHALL be 0, including Run=0, Rout=0, Rin=0, ALU_sel=0 and T_state=0.
REQ-028 On the first rising edge with Clear=0, state SHALL be T0 and Run=1.
REQ-029 Clear mid-instruction SHALL abort the instruction; no Rin, LOin, HIin or PCin pulse for the aborted instruction occurs after Clear rises.

Verification
REQ-030 Clear, then IR=0x22920000 (SUB R5,R2,R4), Mem_ready=1 -> T3: Rout=0x0004, Yin; T4: Rout=0x0010, ALU_sel=0x02, Zin; T5: Zlowout, Rin=0x0020; T_state=0 on cycle 7.
REQ-031 Mem_ready=0 for 3 cycles in T1 -> Read/MDRin high 4 cycles, PCin/Zlowout high 1 cycle (the last), then T2.
REQ-032 IR=0x79180000 (MUL R2,R3) -> T3: Rout=0x0004, Yin; T4: Rout=0x0008, ALU_sel=0x40; T5: LOin; T6: HIin; then T0.
REQ-033 IR=0xD8000000 (HALT) -> T_state=15, Run=0, all outputs 0 for 10+ cycles; Clear pulse -> T0, Run=1.
REQ-034 Clear asserted during T4 of the SUB in REQ-030 -> all outputs 0 in that cycle, no Rin pulse, T0 follows.
REQ-035 IR=0xF8000000 (undefined opcode) -> T3 with all outputs 0, then T0, Run stays 1.
